imem_loader: RTL and testbench

//   Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake
//   and packs it little-endian into 32-bit words. Issues single-cycle word writes at consecutive word

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction memory writer. Takes a host byte stream over a
//   valid/ready handshake, packs four bytes little-endian into a 32-bit
//   word and issues one single-cycle write per word at consecutive word
//   addresses starting at BASE_ADDR. The core is held (cpu_hold) for the
//   whole load.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        begin a load (only honoured in IDLE)
//   load_len     words to load, sampled with start; valid range 1..MAX_WORDS
//   abort        cancel a load in progress
//   byte_valid   host byte available
//   byte_data    host byte
//   byte_ready   loader accepts a byte this cycle
//   we           instruction memory write enable, one pulse per word
//   waddr        write byte address
//   wdata        write data
//   cpu_hold     core held in reset/stall
//   busy         load in progress
//   done         one-cycle pulse once the last word is written
//   err          one-cycle pulse when start is rejected for a bad load_len
//
// Every output is a flop. Control outputs are therefore set on the edge
// that enters the state they belong to (e.g. we is set on the 4th byte
// handshake so it is high for exactly the WRITE cycle).

module imem_loader #(
  parameter int                ADDR_W    = 32,
  parameter int                MAX_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       load_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;

  logic        len_ok;
  logic        last_word;
  logic        take;
  logic [ADDR_W-1:0] word_addr;

  // Zero-extend before comparing so a 16-bit load_len never wraps.
  assign len_ok    = (load_len != 16'd0) && ({1'b0, load_len} <= MAX_LEN);
  // word_idx < len <= MAX_WORDS, so the +1 cannot overflow.
  assign last_word = (word_idx + 16'd1) == len;
  assign take      = byte_valid && byte_ready;
  // Modulo 2^ADDR_W falls out of the fixed-width add.
  assign word_addr = BASE_ADDR + (ADDR_W'(word_idx) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= BASE_ADDR;
      wdata      <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      we   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;

      if (abort && state != IDLE) begin
        // Abort wins over everything: a byte handshaking this cycle is
        // consumed but dropped, and no write or done follows.
        state      <= IDLE;
        byte_idx   <= '0;
        byte_ready <= 1'b0;
        cpu_hold   <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (len_ok) begin
                len        <= load_len;
                word_idx   <= '0;
                byte_idx   <= '0;
                state      <= RECV;
                byte_ready <= 1'b1;
                cpu_hold   <= 1'b1;
                busy       <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end

          RECV: begin
            if (take) begin
              wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                // Word complete: the write happens in the next cycle.
                state      <= WRITE;
                byte_ready <= 1'b0;
                we         <= 1'b1;
                waddr      <= word_addr;
              end
            end
          end

          WRITE: begin
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              word_idx   <= word_idx + 16'd1;
              state      <= RECV;
              byte_ready <= 1'b1;
            end
          end

          DONE: begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end

          default: begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Inputs are driven and outputs sampled on
// the falling edge; a posedge monitor counts write/done/err pulses.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] load_len = '0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, we, cpu_hold, busy, done, err;
  logic [31:0] waddr, wdata;

  int tests = 0;
  int failed = 0;
  int n_we = 0;
  int n_done = 0;
  int n_err = 0;
  int snap_we, snap_done;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(32), .MAX_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err)
  );

  // Values read here are those of the cycle that just ended.
  always @(posedge clk) begin
    if (!rst) begin
      if (we === 1'b1)   n_we++;
      if (done === 1'b1) n_done++;
      if (err === 1'b1)  n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1;
    load_len = len;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it. Returns on the
  // falling edge just after the handshake edge, with byte_valid low.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (byte_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("ready_timeout", 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  initial begin
    // 1: reset, byte_valid high must not see ready
    byte_valid = 1'b1;
    byte_data = 8'h5A;
    tick(2);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_waddr", waddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    tick();

    // 2: two-word load, back-to-back bytes
    check("pre_hold", {31'd0, cpu_hold}, 32'd0);
    do_start(16'd2);
    check("t2_hold", {31'd0, cpu_hold}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("t2_we0", {31'd0, we}, 32'd1);
    check("t2_addr0", waddr, 32'h0);
    check("t2_data0", wdata, 32'h0000_0013);
    check("t2_ready_wr", {31'd0, byte_ready}, 32'd0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check("t2_we1", {31'd0, we}, 32'd1);
    check("t2_addr1", waddr, 32'h4);
    check("t2_data1", wdata, 32'h0010_0093);
    tick();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_hold_done", {31'd0, cpu_hold}, 32'd1);
    tick();
    check("t2_done_end", {31'd0, done}, 32'd0);
    check("t2_hold_end", {31'd0, cpu_hold}, 32'd0);
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_nwe", n_we, 32'd2);
    check("t2_ndone", n_done, 32'd1);

    // 3: rejected lengths
    snap_we = n_we;
    do_start(16'd0);
    check("t3_err0", {31'd0, err}, 32'd1);
    check("t3_busy0", {31'd0, busy}, 32'd0);
    tick();
    check("t3_err0_end", {31'd0, err}, 32'd0);
    do_start(16'd257);
    check("t3_err257", {31'd0, err}, 32'd1);
    check("t3_busy257", {31'd0, busy}, 32'd0);
    tick();
    check("t3_err257_end", {31'd0, err}, 32'd0);
    check("t3_nerr", n_err, 32'd2);
    check("t3_nowe", n_we, snap_we);

    // 4: byte_valid toggling
    do_start(16'd1);
    send_byte(8'hEF); tick();
    send_byte(8'hBE); tick();
    send_byte(8'hAD); tick();
    send_byte(8'hDE);
    check("t4_we", {31'd0, we}, 32'd1);
    check("t4_addr", waddr, 32'h0);
    check("t4_data", wdata, 32'hDEAD_BEEF);
    tick(2);
    check("t4_idle", {31'd0, busy}, 32'd0);

    // 5: abort mid second word, then a fresh load
    snap_we = n_we;
    snap_done = n_done;
    do_start(16'd3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_hold", {31'd0, cpu_hold}, 32'd0);
    check("t5_ready", {31'd0, byte_ready}, 32'd0);
    tick(3);
    check("t5_nwe", n_we, snap_we + 1);
    check("t5_ndone", n_done, snap_done);
    do_start(16'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("t5_addr_new", waddr, 32'h0);
    check("t5_data_new", wdata, 32'h4433_2211);
    tick(2);

    // abort together with the 4th byte: no write
    snap_we = n_we;
    do_start(16'd1);
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
    byte_valid = 1'b1;
    byte_data = 8'hA3;
    abort = 1'b1;
    tick();
    byte_valid = 1'b0;
    abort = 1'b0;
    check("ab4_we", {31'd0, we}, 32'd0);
    check("ab4_busy", {31'd0, busy}, 32'd0);
    tick(2);
    check("ab4_nwe", n_we, snap_we);

    // 6: reset mid-word after one word written
    do_start(16'd2);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_waddr", waddr, 32'h0);
    check("t6_wdata", wdata, 32'h0);
    check("t6_ready", {31'd0, byte_ready}, 32'd0);
    do_start(16'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("t6_we", {31'd0, we}, 32'd1);
    check("t6_addr", waddr, 32'h0);
    check("t6_data", wdata, 32'h0403_0201);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
